multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control sequencer for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath enable and mux select from a registered state. The ALU, register file, instruction register and PC are therefore shared across cycles instead of being duplicated. It sits beside the ALU control block: it feeds it `alu_op`, and it consumes the ALU zero flag.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  when high, permits a new fetch.
- `opcode`  in  6  instruction register bits [31:26]; stable from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `pc_write`  out  1  unconditional PC write.
- `pc_en`  out  1  final PC enable: `pc_write | (branch_state & zero)`.
- `ir_write`  out  1  instruction register load.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `iord`  out  1  memory address select: 0 selects PC, 1 selects ALUOut.
- `reg_dst`  out  1  register write address: 0 selects rd [15:11], 1 selects rt [20:16].
- `mem_to_reg`  out  1  register write data: 0 selects ALUOut, 1 selects memory data.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  ALU A input: 0 selects PC, 1 selects register A.
- `alu_src_b`  out  2  ALU B input: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left by 2.
- `alu_op`  out  2  to ALU control: 00 add, 01 subtract, 10 use funct.
- `pc_src`  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- `instr_done`  out  1  one-cycle pulse in the final state of each retired instruction.
- `illegal_op`  out  1  one-cycle pulse for an unsupported opcode.
- `state`  out  4  current state encoding.
- `retired`  out  CNT_W  count of retired instructions.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=12. Codes 13–15 go to FETCH on the next clock.
- Outputs are a combinational decode of the state register. Any signal not listed for a state is 0.
- FETCH, only when `run`=1: `mem_read`, `ir_write`, `pc_write`, `alu_src_b`=01, then go to DECODE. When `run`=0: all outputs 0 and the block stays in FETCH.
- DECODE: `alu_src_b`=11, `alu_op`=00. Next state by `opcode`:
  - 000000 → EXEC
  - 100011 (lw) and 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode → ILLEGAL
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1, `mem_read`=1, then MEMWB.
- MEMWB: `reg_dst`=1, `mem_to_reg`=1, `reg_write`=1, `instr_done`=1, then FETCH.
- MEMWR: `iord`=1, `mem_write`=1, `instr_done`=1, then FETCH.
- EXEC: `alu_src_a`=1, `alu_op`=10, then ALUWB.
- ALUWB: `reg_dst`=0, `reg_write`=1, `instr_done`=1, then FETCH.
- BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_src`=01, `pc_en`=`zero`, `instr_done`=1, then FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, then ADDIWB.
- ADDIWB: `reg_dst`=1, `reg_write`=1, `instr_done`=1, then FETCH.
- JUMP: `pc_src`=10, `pc_write`=1, `instr_done`=1, then FETCH.
- ILLEGAL: `illegal_op`=1, no register or memory write, no retire, then FETCH. The PC has already advanced by 4.
- `retired` increments on each clock edge where `instr_done`=1. It wraps from all-ones to 0 with no flag.

## Timing
- Reset (`rst_n` low, asynchronous): `state`=FETCH and `retired`=0 take effect immediately. With `run`=0, every output is 0.
- Reset asserted mid-instruction aborts the instruction at once: any pending `reg_write`/`mem_write` is dropped combinationally. The release edge starts from FETCH.
- Cycle counts from FETCH back to FETCH:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 3.
- `run` is sampled only in FETCH. An instruction already past FETCH completes even if `run` falls.
- `zero` is combinational to `pc_en` in BRANCH only; it is ignored in all other states.
- `opcode` is sampled only in DECODE and MEMADR.

## Configuration
- `MULTICYCLE_JUMP_EN` defined: opcode 000010 executes through JUMP as specified above.
- Not defined: JUMP state logic is removed. Opcode 000010 decodes to ILLEGAL, and state code 11 is treated as an unused code (goes to FETCH).

## Test plan
- Reset with `run`=0, then hold 10 cycles → `state`=0, every output 0, `retired`=0.
- `run`=1, `opcode`=100011 → states 0,1,2,3,4. `mem_read` high in states 0 and 3; `reg_write`+`mem_to_reg` high in state 4; `retired`=1.
- `opcode`=000100 with `zero`=1 and then `zero`=0 → `pc_en`=1 and 0 respectively in state 8. Both instructions retire in 3 cycles.
- `opcode`=111111 → states 0,1,12. `illegal_op` pulses once, `instr_done` stays 0, `retired` unchanged. Repeat with 000010 when the macro is undefined and expect the same result.
- Assert `rst_n`=0 while in state 7 (ALUWB) → `reg_write` drops in the same cycle, `state`=0, `retired`=0.
- Preload `retired` to all-ones via 2^CNT_W−1 retirements (use `CNT_W`=4, so 15 R-type instructions), then one more R-type → `retired`=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the MIPS datapath.
// It walks each instruction through FETCH/DECODE and a short per-class
// sequence, and decodes every datapath enable and mux select from the
// current state, so one ALU, register file, IR and PC serve every cycle.
//
// Optional feature macro: MULTICYCLE_JUMP_EN
//   defined     - opcode 000010 (j) executes through the JUMP state.
//   not defined - the JUMP state is removed; j decodes as ILLEGAL and
//                 state code 11 is an unused code that returns to FETCH.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             pc_write,
  output logic             pc_en,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU B-input selects
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_SH2  = 2'b11;

  // ALU control requests
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // PC source selects
  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_OUT  = 2'b01;
  localparam logic [1:0] PCS_JMP  = 2'b10;

  state_t st;

  // Instruction-class dispatch out of DECODE.
  function automatic state_t dispatch(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = S_EXEC;
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_BEQ:       nxt = S_BRANCH;
      OP_ADDI:      nxt = S_ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
      OP_J:         nxt = S_JUMP;
`endif
      default:      nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

  // Memory-access split: only a store goes to MEMWR, loads read memory.
  function automatic state_t mem_split(input logic [5:0] op);
    return (op == OP_SW) ? S_MEMWR : S_MEMRD;
  endfunction

  assign state = st;

  // State sequencing and retired-instruction counter (wraps silently).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_FETCH;
      retired <= '0;
    end else begin
      if (instr_done) begin
        retired <= retired + CNT_W'(1);
      end
      case (st)
        S_FETCH:   st <= run ? S_DECODE : S_FETCH;
        S_DECODE:  st <= dispatch(opcode);
        S_MEMADR:  st <= mem_split(opcode);
        S_MEMRD:   st <= S_MEMWB;
        S_MEMWB:   st <= S_FETCH;
        S_MEMWR:   st <= S_FETCH;
        S_EXEC:    st <= S_ALUWB;
        S_ALUWB:   st <= S_FETCH;
        S_BRANCH:  st <= S_FETCH;
        S_ADDIEX:  st <= S_ADDIWB;
        S_ADDIWB:  st <= S_FETCH;
`ifdef MULTICYCLE_JUMP_EN
        S_JUMP:    st <= S_FETCH;
`endif
        S_ILLEGAL: st <= S_FETCH;
        default:   st <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from the state register; since reset
  // forces the state to FETCH asynchronously, any write strobe of an
  // in-flight instruction disappears as soon as rst_n falls.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_src     = PCS_ALU;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (st)
      S_FETCH: begin
        if (run) begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_SH2;
        alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_dst    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_dst    = 1'b0;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PCS_OUT;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        pc_src     = PCS_JMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
`endif
      S_ILLEGAL: begin
        illegal_op = 1'b1;
      end
      default: begin
        illegal_op = 1'b0;
      end
    endcase
    // The zero flag only reaches the PC enable while resolving a branch.
    pc_en = pc_write | ((st == S_BRANCH) & zero);
  end

endmodule
